desynk: RTL and testbench

DESYNK -- requirements
Module: desynk

---
 rtl/desynk_pkg.sv | 24 ++
 rtl/desynk_clkgen.sv | 51 +++++
 rtl/desynk.sv | 164 ++++++++++++++++
 tb/tb_desynk.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/desynk_pkg.sv
// Shared types and default parameter values for the desynk clock-glitch sequencer.
package desynk_pkg;

   typedef enum logic [2:0] {
      StOff,
      StBoot,
      StWaitRdy,
      StArm,
      StGlitch,
      StCheck,
      StDone
   } state_e;

   localparam int unsigned DefClkDiv       = 2;
   localparam int unsigned DefDelayMax     = 15;
   localparam int unsigned DefReadyTimeout = 32;
   localparam int unsigned DefOffCycles    = 4;
   localparam int unsigned DefCheckCycles  = 8;

   function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/desynk_clkgen.sv
// Target clock divider: 50% duty, restartable, gateable, and able to swallow one rising edge.
module desynk_clkgen
   import desynk_pkg::*;
#(
   parameter int unsigned CLK_DIV = DefClkDiv
) (
   input  logic clk,
   input  logic i_rst,
   input  logic i_restart,
   input  logic i_gate,
   input  logic i_drop,
   output logic o_tclk,
   output logic o_wrap
);

   localparam int unsigned CntW = $clog2(CLK_DIV);
   localparam logic [CntW-1:0] CntMax = CntW'(CLK_DIV - 1);
   localparam logic [CntW-1:0] Half   = CntW'(CLK_DIV / 2);

   logic [CntW-1:0] r_cnt;
   logic [CntW-1:0] w_cnt_nxt;
   logic            r_tclk;
   logic            r_drop;
   logic            w_wrap;
   logic            w_drop_nxt;

   // A wrap is the point where the next target period (and its rising edge) begins.
   assign w_wrap     = (r_cnt == CntMax);
   assign w_cnt_nxt  = w_wrap ? '0 : r_cnt + 1'b1;
   assign w_drop_nxt = w_wrap ? i_drop : r_drop;

   always_ff @(posedge clk) begin
      if (i_rst) begin
         r_cnt  <= '0;
         r_tclk <= 1'b0;
         r_drop <= 1'b0;
      end else if (i_restart) begin
         r_cnt  <= '0;
         r_tclk <= 1'b1;
         r_drop <= 1'b0;
      end else begin
         r_cnt  <= w_cnt_nxt;
         r_drop <= w_drop_nxt;
         r_tclk <= !i_gate && !w_drop_nxt && (w_cnt_nxt < Half);
      end
   end

   assign o_tclk = r_tclk;
   assign o_wrap = w_wrap;

endmodule

// File: rtl/desynk.sv
// Clock-glitch sweep controller. Define DESYNK_POWER_CYCLE_EN to power-cycle the target
// after every failed attempt; otherwise retries go straight back to soft-reset boot.
module desynk
   import desynk_pkg::*;
#(
   parameter int unsigned CLK_DIV       = DefClkDiv,
   parameter int unsigned DELAY_MAX     = DefDelayMax,
   parameter int unsigned READY_TIMEOUT = DefReadyTimeout,
   parameter int unsigned OFF_CYCLES    = DefOffCycles,
   parameter int unsigned CHECK_CYCLES  = DefCheckCycles
) (
   input  logic clk,
   input  logic io_reset,
   output logic io_target_clk,
   output logic io_target_reset,
   output logic io_target_power,
   output logic io_target_throttle,
   input  logic io_target_ready,
   input  logic io_target_success
);

`ifdef DESYNK_POWER_CYCLE_EN
   localparam bit PowerCycle = 1'b1;
`else
   localparam bit PowerCycle = 1'b0;
`endif

   localparam state_e RetryState = PowerCycle ? StOff : StBoot;

   localparam int unsigned DelayW = (DELAY_MAX > 0) ? $clog2(DELAY_MAX + 1) : 1;
   localparam int unsigned CntTop = max_u(max_u(OFF_CYCLES, 2 * CLK_DIV),
                                          max_u(max_u(READY_TIMEOUT, CHECK_CYCLES),
                                                DELAY_MAX + 1));
   localparam int unsigned CntW   = $clog2(CntTop);

   localparam logic [CntW-1:0]   OffLast  = CntW'(OFF_CYCLES - 1);
   localparam logic [CntW-1:0]   BootLast = CntW'(2 * CLK_DIV - 1);
   localparam logic [CntW-1:0]   RdyLast  = CntW'(READY_TIMEOUT - 1);
   localparam logic [CntW-1:0]   ChkLast  = CntW'(CHECK_CYCLES - 1);
   localparam logic [DelayW-1:0] DelayTop = DelayW'(DELAY_MAX);

   state_e            r_state;
   logic [CntW-1:0]   r_cnt;
   logic [DelayW-1:0] r_delay;
   logic              r_power;
   logic              r_treset;
   logic              r_throttle;

   logic            w_wrap;
   logic            w_restart;
   logic            w_gate;
   logic            w_drop;
   logic            w_retry;
   logic [CntW-1:0] w_delay_ext;

   assign w_delay_ext = CntW'(r_delay);
   assign w_restart   = (r_state == StOff) && (r_cnt == OffLast);
   assign w_retry     = ((r_state == StWaitRdy) && !io_target_ready && (r_cnt == RdyLast)) ||
                        ((r_state == StCheck) && !io_target_success && (r_cnt == ChkLast));
   // Gate one cycle early on a retry into OFF so the registered clock is already low there.
   assign w_gate      = (r_state == StOff) || (PowerCycle && w_retry);
   assign w_drop      = (r_state == StArm) && (r_cnt == w_delay_ext);

   desynk_clkgen #(
      .CLK_DIV(CLK_DIV)
   ) u_clkgen (
      .clk      (clk),
      .i_rst    (io_reset),
      .i_restart(w_restart),
      .i_gate   (w_gate),
      .i_drop   (w_drop),
      .o_tclk   (io_target_clk),
      .o_wrap   (w_wrap)
   );

   always_ff @(posedge clk) begin
      if (io_reset) begin
         r_state    <= StOff;
         r_cnt      <= '0;
         r_delay    <= '0;
         r_power    <= 1'b0;
         r_treset   <= 1'b1;
         r_throttle <= 1'b0;
      end else begin
         unique case (r_state)
            StOff: begin
               if (w_restart) begin
                  r_state <= StBoot;
                  r_cnt   <= '0;
                  r_power <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            StBoot: begin
               if (r_cnt == BootLast) begin
                  r_state  <= StWaitRdy;
                  r_cnt    <= '0;
                  r_treset <= 1'b0;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            StWaitRdy: begin
               if (io_target_ready) begin
                  r_state    <= StArm;
                  r_cnt      <= '0;
                  r_throttle <= 1'b1;
               end else if (w_retry) begin
                  r_state  <= RetryState;
                  r_cnt    <= '0;
                  r_power  <= !PowerCycle;
                  r_treset <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            // Count real rising edges; the wrap after the last one is swallowed by the divider.
            StArm: begin
               if (w_wrap) begin
                  if (r_cnt == w_delay_ext) begin
                     r_state <= StGlitch;
                     r_cnt   <= '0;
                  end else begin
                     r_cnt <= r_cnt + 1'b1;
                  end
               end
            end
            StGlitch: begin
               if (w_wrap) begin
                  r_state    <= StCheck;
                  r_cnt      <= '0;
                  r_throttle <= 1'b0;
               end
            end
            StCheck: begin
               if (io_target_success) begin
                  r_state <= StDone;
                  r_cnt   <= '0;
               end else if (w_retry) begin
                  r_delay  <= (r_delay == DelayTop) ? '0 : r_delay + 1'b1;
                  r_state  <= RetryState;
                  r_cnt    <= '0;
                  r_power  <= !PowerCycle;
                  r_treset <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            StDone: begin
               r_state <= StDone;
            end
            default: begin
               r_state <= StOff;
            end
         endcase
      end
   end

   assign io_target_power    = r_power;
   assign io_target_reset    = r_treset;
   assign io_target_throttle = r_throttle;

endmodule

// File: tb/tb_desynk.sv
// Bench for desynk: boot-sequence vector table, timeout, sweep, success, and reset-in-glitch.
`timescale 1ns/1ps
module tb_desynk;

`ifdef DESYNK_POWER_CYCLE_EN
   localparam bit PwrCyc = 1'b1;
`else
   localparam bit PwrCyc = 1'b0;
`endif

   localparam int ClkDiv   = 2;
   localparam int DelayMax = 15;
   localparam int RdyTo    = 32;

   logic clk = 1'b0;
   logic io_reset = 1'b1;
   logic ready = 1'b0;
   logic success = 1'b0;
   logic tclk, trst, pwr, thr;

   desynk #(
      .CLK_DIV      (ClkDiv),
      .DELAY_MAX    (DelayMax),
      .READY_TIMEOUT(RdyTo),
      .OFF_CYCLES   (4),
      .CHECK_CYCLES (8)
   ) dut (
      .clk               (clk),
      .io_reset          (io_reset),
      .io_target_clk     (tclk),
      .io_target_reset   (trst),
      .io_target_power   (pwr),
      .io_target_throttle(thr),
      .io_target_ready   (ready),
      .io_target_success (success)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Target / observer model, evaluated at the falling edge away from DUT updates.
   bit   ready_en = 0;
   bit   noise_en = 0;
   int   succ_mode = 0;
   int   rises = 0, run = 0, last_run = 0, rdy_cnt = 0, rdy_lat = 3 * ClkDiv;
   int   succ_left = 0, pwr_falls = 0;
   bit   glitch_seen = 0;
   logic p_tclk = 1'b0, p_thr = 1'b0, p_pwr = 1'b0;
   int   q_off[$];
   int   q_run[$];

   initial forever begin
      @(negedge clk);
      if (tclk === 1'b1 && p_tclk === 1'b0) last_run = run;
      run = (tclk === 1'b1) ? 0 : run + 1;
      if (thr === 1'b1 && p_thr !== 1'b1) begin
         rises = 0;
         glitch_seen = 0;
      end
      if (thr === 1'b1 && p_thr === 1'b1 && tclk === 1'b1 && p_tclk === 1'b0) rises++;
      if (thr === 1'b1 && tclk === 1'b0 && run > ClkDiv / 2) glitch_seen = 1;
      // Attempt ends when the clock resumes and throttle drops on the same edge.
      if (thr === 1'b0 && p_thr === 1'b1 && tclk === 1'b1 && p_tclk === 1'b0) begin
         q_off.push_back(rises);
         q_run.push_back(last_run);
         glitch_seen = 0;
         if (succ_mode == 1 && rises == 5) succ_left = 3;
      end
      if (pwr === 1'b0 && p_pwr === 1'b1) pwr_falls++;
      if (pwr !== 1'b1 || trst !== 1'b0) begin
         rdy_cnt = 0;
         rdy_lat = noise_en ? 3 * ClkDiv + int'($urandom_range(0, 4)) : 3 * ClkDiv;
      end else begin
         rdy_cnt++;
      end
      ready = ready_en && (rdy_cnt >= rdy_lat) &&
              !(noise_en && thr === 1'b1 && $urandom_range(0, 1) == 1);
      if (succ_left > 0) begin
         success = 1'b1;
         succ_left--;
      end else begin
         success = noise_en && (trst === 1'b1 || thr === 1'b1) && ($urandom_range(0, 3) == 0);
      end
      p_tclk = tclk;
      p_thr  = thr;
      p_pwr  = pwr;
   end

   task automatic wait_attempts(input int n, input int limit, input string name);
      int k = 0;
      while (q_off.size() < n && k < limit) begin
         @(posedge clk);
         k++;
      end
      #1;
      check({name, " attempts"}, q_off.size() >= n, 1);
   endtask

   task automatic pulse_reset();
      io_reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      io_reset = 1'b0;
      q_off.delete();
      q_run.delete();
   endtask

   typedef struct {
      logic rst;
      logic pwr;
      logic trst;
      logic thr;
      logic tclk;
   } vec_t;

   vec_t tbl[11];

   initial begin
      int n;
      int k;
      int cnt;
      logic pt;

      tbl[0]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
      tbl[1]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
      tbl[2]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      tbl[3]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      tbl[4]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      tbl[5]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
      tbl[6]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      tbl[7]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
      tbl[8]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      tbl[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
      tbl[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

      // Reset and first boot, cycle by cycle.
      for (int i = 0; i < 11; i++) begin
         io_reset = tbl[i].rst;
         @(posedge clk);
         #1;
         check($sformatf("vec%0d power", i), pwr, tbl[i].pwr);
         check($sformatf("vec%0d treset", i), trst, tbl[i].trst);
         check($sformatf("vec%0d throttle", i), thr, tbl[i].thr);
         check($sformatf("vec%0d tclk", i), tclk, tbl[i].tclk);
      end

      // Ready never comes: two timeouts of READY_TIMEOUT cycles each.
      for (int t = 0; t < 2; t++) begin
         k = 0;
         while (trst !== 1'b0 && k < 100) begin
            @(posedge clk);
            #1;
            k++;
         end
         n = 0;
         while (trst === 1'b0 && n < 200) begin
            n++;
            @(posedge clk);
            #1;
         end
         if (t == 0) n = n + 1;
         check($sformatf("timeout%0d length", t), n, RdyTo);
         check($sformatf("timeout%0d power", t), pwr, !PwrCyc);
      end

      // Sweep with no success: delay 0..15 then wrap to 0.
      repeat (2) @(posedge clk);
      #1;
      pwr_falls = 0;
      q_off.delete();
      q_run.delete();
      noise_en = 1;
      ready_en = 1;
      succ_mode = 0;
      wait_attempts(17, 4000, "sweep");
      for (int i = 0; i < q_off.size() && i < 17; i++) begin
         check($sformatf("sweep%0d offset", i), q_off[i], i % (DelayMax + 1));
         check($sformatf("sweep%0d dropped low run", i), q_run[i], ClkDiv * 3 / 2);
      end
      check("sweep power falls", pwr_falls, PwrCyc ? 16 : 0);

      // Success only at offset 5: terminal DONE after the sixth attempt.
      pulse_reset();
      pwr_falls = 0;
      succ_mode = 1;
      wait_attempts(6, 2000, "success");
      repeat (10) @(posedge clk);
      #1;
      cnt = 0;
      pt = tclk;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         #1;
         if (tclk === 1'b1 && pt === 1'b0) cnt++;
         pt = tclk;
      end
      check("done attempt count", q_off.size(), 6);
      for (int i = 0; i < q_off.size() && i < 6; i++)
         check($sformatf("done attempt%0d offset", i), q_off[i], i);
      check("done power falls", pwr_falls, PwrCyc ? 5 : 0);
      check("done power", pwr, 1);
      check("done treset", trst, 0);
      check("done throttle", thr, 0);
      check("done tclk rises", cnt, 40 / ClkDiv);

      // Reset in the middle of the dropped period of the delay-3 attempt.
      succ_mode = 0;
      pulse_reset();
      k = 0;
      while (!(q_off.size() == 3 && glitch_seen) && k < 2000) begin
         @(posedge clk);
         k++;
      end
      #1;
      check("glitch reached", k < 2000, 1);
      io_reset = 1'b1;
      @(posedge clk);
      #1;
      check("glitch reset tclk", tclk, 0);
      check("glitch reset power", pwr, 0);
      check("glitch reset treset", trst, 1);
      check("glitch reset throttle", thr, 0);
      @(posedge clk);
      #1;
      io_reset = 1'b0;
      q_off.delete();
      q_run.delete();
      wait_attempts(1, 1000, "post reset");
      if (q_off.size() > 0) check("post reset delay", q_off[0], 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
